// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall / branch flush control and operand forwarding select; optional perf counters under HAZARD_PERF_CNT_EN.
// Latency: stall, flush and forward selects are combinational; stall extension and counters update one cycle later.
// Backpressure: none accepted; this block generates the pipeline holds itself.
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hazard;
    logic             stall;

    // Register 0 is hard-wired zero, so a load to it never creates a dependency.
    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    assign stall = !reset && !ex_branch_taken && ((state == LSTALL) || hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (ex_branch_taken) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == LSTALL) begin
            if (cnt <= CNT_ONE) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end else if (hazard && (LOAD_LAT > 1)) begin
            state <= LSTALL;
            cnt   <= CNT_INIT;
        end
    end

    always_comb begin
        pc_hold     = stall;
        ifid_hold   = stall;
        idex_bubble = stall || (!reset && ex_branch_taken);
        ifid_flush  = !reset && ex_branch_taken;
    end

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!reset) begin
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))
                fwd_a = 2'b10;
            else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))
                fwd_a = 2'b01;
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))
                fwd_b = 2'b10;
            else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))
                fwd_b = 2'b01;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    // Saturating so a long-running counter reads as "at least" rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_hold && (stall_q != '1))
                stall_q <= stall_q + PERF_W'(1);
            if (ifid_flush && (flush_q != '1))
                flush_q <= flush_q + PERF_W'(1);
        end
    end

    assign perf_stall_cycles = reset ? '0 : stall_q;
    assign perf_flushes      = reset ? '0 : flush_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two instances (LOAD_LAT=3 with 4-bit counters, LOAD_LAT=1) driven from shared inputs.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_reg_write, wb_reg_write;

    logic       pc_hold_3, ifid_hold_3, idex_bubble_3, ifid_flush_3;
    logic [1:0] fwd_a_3, fwd_b_3;
    logic [3:0] perf_stall_3, perf_flush_3;

    logic       pc_hold_1, ifid_hold_1, idex_bubble_1, ifid_flush_1;
    logic [1:0] fwd_a_1, fwd_b_1;
    logic [15:0] perf_stall_1, perf_flush_1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_hold(pc_hold_3), .ifid_hold(ifid_hold_3), .idex_bubble(idex_bubble_3),
        .ifid_flush(ifid_flush_3), .fwd_a(fwd_a_3), .fwd_b(fwd_b_3),
        .perf_stall_cycles(perf_stall_3), .perf_flushes(perf_flush_3)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(16)) u_dut1 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_hold(pc_hold_1), .ifid_hold(ifid_hold_1), .idex_bubble(idex_bubble_1),
        .ifid_flush(ifid_flush_1), .fwd_a(fwd_a_1), .fwd_b(fwd_b_1),
        .perf_stall_cycles(perf_stall_1), .perf_flushes(perf_flush_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0; ex_branch_taken = 0;
        mem_rd = '0; wb_rd = '0; mem_reg_write = 0; wb_reg_write = 0;
    endtask

    task automatic load_use_hazard();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        // Reset gating: even with hazard, branch and forwarding inputs active, outputs stay low
        load_use_hazard();
        ex_branch_taken = 1;
        mem_rd = 5'd7; mem_reg_write = 1; ex_rs1 = 5'd7;
        #1;
        chk("rst_pc_hold", pc_hold_3, 0);
        chk("rst_flush", ifid_flush_3, 0);
        chk("rst_bubble", idex_bubble_3, 0);
        chk("rst_fwd_a", fwd_a_3, 0);
        tick();
        tick();
        chk("rst_perf_stall", perf_stall_3, 0);
        reset = 0;
        clear_inputs();
        tick();

        // Load-use hazard: 3 stall cycles for LOAD_LAT=3, 1 for LOAD_LAT=1
        load_use_hazard();
        #1;
        chk("lu_c1_pc_hold3", pc_hold_3, 1);
        chk("lu_c1_ifid_hold3", ifid_hold_3, 1);
        chk("lu_c1_bubble3", idex_bubble_3, 1);
        chk("lu_c1_flush3", ifid_flush_3, 0);
        chk("lu_c1_pc_hold1", pc_hold_1, 1);
        tick();
        clear_inputs();
        #1;
        chk("lu_c2_pc_hold3", pc_hold_3, 1);
        chk("lu_c2_bubble3", idex_bubble_3, 1);
        chk("lu_c2_pc_hold1", pc_hold_1, 0);
        chk("lu_c2_bubble1", idex_bubble_1, 0);
        tick();
        chk("lu_c3_pc_hold3", pc_hold_3, 1);
        tick();
        chk("lu_c4_pc_hold3", pc_hold_3, 0);
        chk("lu_c4_bubble3", idex_bubble_3, 0);

        // Branch in the 2nd stall cycle overrides LSTALL
        tick();
        load_use_hazard();
        #1;
        chk("br_c1_pc_hold3", pc_hold_3, 1);
        tick();
        clear_inputs();
        ex_branch_taken = 1;
        #1;
        chk("br_c2_flush3", ifid_flush_3, 1);
        chk("br_c2_bubble3", idex_bubble_3, 1);
        chk("br_c2_pc_hold3", pc_hold_3, 0);
        chk("br_c2_ifid_hold3", ifid_hold_3, 0);
        tick();
        ex_branch_taken = 0;
        #1;
        chk("br_c3_pc_hold3", pc_hold_3, 0);
        chk("br_c3_flush3", ifid_flush_3, 0);

        // Register 0 and unused sources never stall
        tick();
        ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
        #1;
        chk("x0_no_stall", pc_hold_3, 0);
        ex_rd = 5'd6; id_rs1 = 5'd3; id_rs2 = 5'd6; id_use_rs2 = 0;
        #1;
        chk("unused_rs2_no_stall", pc_hold_3, 0);
        id_use_rs2 = 1;
        #1;
        chk("rs2_stall1", pc_hold_1, 1);
        chk("rs2_stall3", pc_hold_3, 1);
        tick();
        clear_inputs();
        tick();
        tick();
        chk("rs2_drained", pc_hold_3, 0);

        // Simultaneous hazard and branch: flush wins, no stall follows
        load_use_hazard();
        ex_branch_taken = 1;
        #1;
        chk("hzbr_flush", ifid_flush_3, 1);
        chk("hzbr_pc_hold", pc_hold_3, 0);
        tick();
        clear_inputs();
        #1;
        chk("hzbr_next_pc_hold", pc_hold_3, 0);

        // Forwarding priority
        mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 5'd7;
        #1;
        chk("fwd_a_mem", fwd_a_3, 2'b10);
        mem_reg_write = 0;
        #1;
        chk("fwd_a_wb", fwd_a_3, 2'b01);
        ex_rs2 = 5'd7; mem_reg_write = 1; mem_rd = 5'd9;
        #1;
        chk("fwd_b_wb", fwd_b_3, 2'b01);
        mem_rd = 5'd7;
        #1;
        chk("fwd_b_mem", fwd_b_3, 2'b10);
        mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
        #1;
        chk("fwd_a_x0", fwd_a_3, 2'b00);
        wb_rd = 5'd4; ex_rs1 = 5'd4; wb_reg_write = 0;
        #1;
        chk("fwd_a_no_we", fwd_a_3, 2'b00);
        clear_inputs();

        // Performance counters: flushes, saturation, and reset during LSTALL
        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("perf_stall_cleared", perf_stall_3, 0);
        ex_branch_taken = 1;
        tick();
        tick();
        ex_branch_taken = 0;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_flushes_2", perf_flush_3, 4'd2);
`else
        chk("perf_flushes_tied", perf_flush_3, 4'd0);
`endif
        load_use_hazard();
        for (int i = 0; i < 20; i++) tick();
        chk("long_stall_pc_hold", pc_hold_3, 1);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_sat", perf_stall_3, 4'd15);
`else
        chk("perf_stall_tied", perf_stall_3, 4'd0);
`endif
        reset = 1;
        tick();
        reset = 0;
        clear_inputs();
        #1;
        chk("rst_abandons_lstall", pc_hold_3, 0);
        chk("perf_stall_after_rst", perf_stall_3, 0);
        chk("perf_flush_after_rst", perf_flush_3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
